// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register for the RV32I core.
// Owns the load-use bubble / downstream-hold decision and keeps hazard debug counters.
`default_nettype none

module id_ex_pipe #(
  parameter int XLEN      = 32,
  parameter int RAW       = 5,
  parameter int OPW       = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [OPW-1:0]   id_aluop,
  input  logic [2:0]       id_alusel,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             id_rsuc1,
  input  logic             id_rsuc2,
  input  logic [XLEN-1:0]  id_reg1,
  input  logic [XLEN-1:0]  id_reg2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RAW-1:0]   id_wd,
  input  logic             id_wreg,
  input  logic             id_is_load,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             stall_req_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [OPW-1:0]   ex_aluop,
  output logic [2:0]       ex_alusel,
  output logic [XLEN-1:0]  ex_reg1,
  output logic [XLEN-1:0]  ex_reg2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RAW-1:0]   ex_wd,
  output logic             ex_wreg,
  output logic             ex_is_load,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam int RCW = $clog2(MAX_STALL + 1);
  localparam logic [RCW-1:0] C_MAX_RUN = RCW'(MAX_STALL);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HAZ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [RCW-1:0] r_run_cnt;
  logic [RCW-1:0] w_run_inc;
  logic           w_ready;
  logic           w_hazard;

  always_comb begin
    w_ready      = (!id_re1 || id_rsuc1) && (!id_re2 || id_rsuc2);
    w_hazard     = id_valid && !w_ready && !rst;
    stall_req_id = !rst && (w_hazard || ex_stall);
  end

  // Edge priority: flush > ex_stall > hazard > advance (rst handled in the register).
  always_comb begin
    w_state_nxt = S_RUN;
    if (flush)         w_state_nxt = S_RUN;
    else if (ex_stall) w_state_nxt = S_HOLD;
    else if (w_hazard) w_state_nxt = S_HAZ;
    else               w_state_nxt = S_RUN;
  end

  // run_cnt is always zero in RUN, so a hazard starting from RUN begins a fresh run.
  always_comb begin
    w_run_inc = '0;
    if (r_state == S_RUN)          w_run_inc = RCW'(1);
    else if (r_run_cnt < C_MAX_RUN) w_run_inc = r_run_cnt + RCW'(1);
    else                           w_run_inc = r_run_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_run_cnt     <= '0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_aluop      <= '0;
      ex_alusel     <= '0;
      ex_reg1       <= '0;
      ex_reg2       <= '0;
      ex_imm        <= '0;
      ex_wd         <= '0;
      ex_wreg       <= 1'b0;
      ex_is_load    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != S_HOLD) begin
        // Bubbles carry ex_wd = 0 so the EX forwarding compare can never match them.
        ex_valid   <= 1'b0;
        ex_pc      <= '0;
        ex_aluop   <= '0;
        ex_alusel  <= '0;
        ex_reg1    <= '0;
        ex_reg2    <= '0;
        ex_imm     <= '0;
        ex_wd      <= '0;
        ex_wreg    <= 1'b0;
        ex_is_load <= 1'b0;
        if (w_state_nxt == S_HAZ) begin
          r_run_cnt <= w_run_inc;
          if (w_run_inc == C_MAX_RUN) stall_timeout <= 1'b1;
          if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
          r_run_cnt <= '0;
          if (!flush && id_valid) begin
            ex_valid   <= 1'b1;
            ex_pc      <= id_pc;
            ex_aluop   <= id_aluop;
            ex_alusel  <= id_alusel;
            ex_reg1    <= id_reg1;
            ex_reg2    <= id_reg2;
            ex_imm     <= id_imm;
            ex_wd      <= id_wd;
            ex_wreg    <= id_wreg;
            ex_is_load <= id_is_load;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed self-checking bench for id_ex_pipe (MAX_STALL overridden to 4).
`default_nettype none

module tb_id_ex_pipe;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic        id_re1, id_re2, id_rsuc1, id_rsuc2;
  logic [31:0] id_reg1, id_reg2, id_imm;
  logic [4:0]  id_wd;
  logic        id_wreg, id_is_load;
  logic        ex_stall, flush;
  logic        stall_req_id;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2, ex_imm;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_is_load;
  logic [15:0] stall_cnt;
  logic        stall_timeout;

  int compared   = 0;
  int mismatched = 0;

  id_ex_pipe #(
    .XLEN(32), .RAW(5), .OPW(8), .CNT_W(16), .MAX_STALL(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_re1(id_re1), .id_re2(id_re2), .id_rsuc1(id_rsuc1), .id_rsuc2(id_rsuc2),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_is_load(id_is_load),
    .ex_stall(ex_stall), .flush(flush),
    .stall_req_id(stall_req_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_imm(ex_imm),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    id_valid = 1'b1; id_re1 = 1'b1; id_rsuc1 = 1'b0; id_re2 = 1'b1; id_rsuc2 = 1'b1;
    id_pc = $urandom; id_aluop = 8'($urandom); id_alusel = 3'($urandom);
    id_reg1 = $urandom; id_reg2 = $urandom; id_imm = $urandom;
    id_wd = 5'($urandom); id_wreg = 1'b1; id_is_load = 1'b1;
    #1;
    check("rst_stall_req_comb", 64'(stall_req_id), 64'd0);
    tick(); tick();
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_pc", 64'(ex_pc), 64'd0);
    check("rst_ex_reg1", 64'(ex_reg1), 64'd0);
    check("rst_ex_wd", 64'(ex_wd), 64'd0);
    check("rst_ex_is_load", 64'(ex_is_load), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_timeout", 64'(stall_timeout), 64'd0);
    check("rst_stall_req", 64'(stall_req_id), 64'd0);

    // Advance
    rst = 1'b0;
    id_valid = 1'b1; id_pc = 32'h100; id_aluop = 8'h21; id_alusel = 3'd1;
    id_re1 = 1'b1; id_re2 = 1'b1; id_rsuc1 = 1'b1; id_rsuc2 = 1'b1;
    id_reg1 = 32'h11; id_reg2 = 32'h22; id_imm = 32'h44; id_wd = 5'd5; id_wreg = 1'b1; id_is_load = 1'b0;
    #1;
    check("adv_stall_req", 64'(stall_req_id), 64'd0);
    tick();
    check("adv_ex_reg1", 64'(ex_reg1), 64'h11);
    check("adv_ex_reg2", 64'(ex_reg2), 64'h22);
    check("adv_ex_wd", 64'(ex_wd), 64'd5);
    check("adv_ex_wreg", 64'(ex_wreg), 64'd1);
    check("adv_ex_valid", 64'(ex_valid), 64'd1);
    check("adv_ex_pc", 64'(ex_pc), 64'h100);
    check("adv_ex_aluop", 64'(ex_aluop), 64'h21);
    check("adv_ex_imm", 64'(ex_imm), 64'h44);
    check("adv_stall_req_after", 64'(stall_req_id), 64'd0);

    // Load-use
    id_rsuc1 = 1'b0; id_reg1 = 32'hDEAD;
    #1;
    check("lu_stall_req", 64'(stall_req_id), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_wd", 64'(ex_wd), 64'd0);
    check("lu_bubble_wreg", 64'(ex_wreg), 64'd0);
    check("lu_bubble_reg1", 64'(ex_reg1), 64'd0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    id_rsuc1 = 1'b1; id_reg1 = 32'h33;
    #1;
    check("lu_release_req", 64'(stall_req_id), 64'd0);
    tick();
    check("lu_ex_reg1", 64'(ex_reg1), 64'h33);
    check("lu_ex_valid", 64'(ex_valid), 64'd1);

    // Disabled read never hazards
    id_re1 = 1'b0; id_rsuc1 = 1'b0; id_re2 = 1'b1; id_rsuc2 = 1'b1; id_reg1 = 32'h55; id_wd = 5'd7;
    #1;
    check("dis_stall_req", 64'(stall_req_id), 64'd0);
    tick();
    check("dis_ex_valid", 64'(ex_valid), 64'd1);
    check("dis_ex_wd", 64'(ex_wd), 64'd7);
    check("dis_ex_reg1", 64'(ex_reg1), 64'h55);
    check("dis_stall_cnt", 64'(stall_cnt), 64'd1);

    // Downstream hold with a pending hazard
    ex_stall = 1'b1; id_re1 = 1'b1; id_rsuc1 = 1'b0; id_wd = 5'd9; id_reg1 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall_req", 64'(stall_req_id), 64'd1);
      tick();
      check("hold_ex_wd", 64'(ex_wd), 64'd7);
      check("hold_ex_reg1", 64'(ex_reg1), 64'h55);
      check("hold_ex_valid", 64'(ex_valid), 64'd1);
      check("hold_stall_cnt", 64'(stall_cnt), 64'd1);
    end
    ex_stall = 1'b0;
    #1;
    check("hold_rel_req", 64'(stall_req_id), 64'd1);
    tick();
    check("hold_rel_valid", 64'(ex_valid), 64'd0);
    check("hold_rel_wd", 64'(ex_wd), 64'd0);
    check("hold_rel_cnt", 64'(stall_cnt), 64'd2);
    id_rsuc1 = 1'b1;
    tick();
    check("hold_adv_wd", 64'(ex_wd), 64'd9);
    check("hold_adv_reg1", 64'(ex_reg1), 64'h99);

    // Flush beats ex_stall and hazard
    flush = 1'b1; ex_stall = 1'b1; id_rsuc1 = 1'b0;
    #1;
    check("fl_stall_req", 64'(stall_req_id), 64'd1);
    tick();
    check("fl_valid", 64'(ex_valid), 64'd0);
    check("fl_wd", 64'(ex_wd), 64'd0);
    check("fl_reg1", 64'(ex_reg1), 64'd0);
    check("fl_stall_cnt", 64'(stall_cnt), 64'd2);
    flush = 1'b0; ex_stall = 1'b0;

    // Timeout after 4 consecutive hazard edges
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("to_before", 64'(stall_timeout), 64'd0);
    end
    tick();
    check("to_set", 64'(stall_timeout), 64'd1);
    check("to_stall_cnt", 64'(stall_cnt), 64'd6);
    id_rsuc1 = 1'b1;
    tick();
    check("to_sticky", 64'(stall_timeout), 64'd1);
    check("to_adv_valid", 64'(ex_valid), 64'd1);
    id_valid = 1'b0;
    tick();
    check("inv_valid", 64'(ex_valid), 64'd0);
    check("inv_wd", 64'(ex_wd), 64'd0);
    check("inv_wreg", 64'(ex_wreg), 64'd0);

    // Reset mid-stall
    id_valid = 1'b1; id_rsuc1 = 1'b0; ex_stall = 1'b1; rst = 1'b1;
    #1;
    check("rst2_stall_req", 64'(stall_req_id), 64'd0);
    tick();
    check("rst2_timeout", 64'(stall_timeout), 64'd0);
    check("rst2_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst2_ex_pc", 64'(ex_pc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
